// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the source-domain req/ack CDC sender.
//   state_e          : FSM state encoding (S_IDLE=0, S_REQ=1, S_REL=2)
//   SYNC_STAGES_DEF  : default depth of the ack synchronizer
//   DATASIZE_DEF     : default transferred word width
//   cnt_width()      : timeout counter width, never narrower than 8 bits
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DATASIZE_DEF    = 8;

  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    int unsigned w;
    w = $clog2(max_cnt + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/cdc_hs_sender_if.sv
// Bundle of the local valid/ready port and the cross-domain req/ack port of the sender.
//   src_valid/src_ready/src_data : local word offer
//   xfer_req/xfer_data           : request and held word towards the destination domain
//   xfer_ack_async               : ack from the destination domain, asynchronous
//   xfer_done                    : handshake-complete pulse
//   err_timeout                  : abort pulse (only with CDC_HS_TIMEOUT_EN)
// Modports: slave = the sender itself, master = the environment driving it.
// Configuration macro: CDC_HS_TIMEOUT_EN adds err_timeout.
interface cdc_hs_sender_if #(
  parameter int unsigned DATASIZE = 8
) ();

  logic                src_valid;
  logic                src_ready;
  logic [DATASIZE-1:0] src_data;
  logic                xfer_req;
  logic [DATASIZE-1:0] xfer_data;
  logic                xfer_ack_async;
  logic                xfer_done;
`ifdef CDC_HS_TIMEOUT_EN
  logic                err_timeout;
`endif

  modport slave (
    input  src_valid,
    output src_ready,
    input  src_data,
    output xfer_req,
    output xfer_data,
    input  xfer_ack_async,
`ifdef CDC_HS_TIMEOUT_EN
    output err_timeout,
`endif
    output xfer_done
  );

  modport master (
    output src_valid,
    input  src_ready,
    output src_data,
    input  xfer_req,
    input  xfer_data,
    output xfer_ack_async,
`ifdef CDC_HS_TIMEOUT_EN
    input  err_timeout,
`endif
    input  xfer_done
  );

endinterface

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk      : destination (here: source-domain) clock
//   rst      : synchronous, active-high reset, clears every stage to 0
//   i_async  : asynchronous input level
//   o_sync   : input delayed through SYNC_STAGES flops
module cdc_ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_sender.sv
// Source-domain end of a 4-phase req/ack clock-domain-crossing handshake.
// Accepts one word on a valid/ready port, holds it on xfer_data, raises xfer_req, and
// waits for the synchronized ack to rise (req drops) and fall again (xfer_done pulses).
//   clk  : source-domain clock
//   rst  : synchronous, active-high reset
//   bus  : cdc_hs_sender_if.slave (src_*, xfer_*, err_timeout)
// Configuration macro: CDC_HS_TIMEOUT_EN adds a TIMEOUT_CYCLES abort from S_REQ with an
// err_timeout pulse; an aborted transfer still finishes S_REL but does not pulse xfer_done.
module cdc_hs_sender
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATASIZE       = DATASIZE_DEF,
`ifdef CDC_HS_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input logic            clk,
  input logic            rst,
  cdc_hs_sender_if.slave bus
);

  state_e              r_state, w_state_nxt;
  logic                r_req, w_req_nxt;
  logic [DATASIZE-1:0] r_data, w_data_nxt;
  logic                r_done, w_done_nxt;
  logic                w_ack_s;
  logic                w_ready;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic             r_abort, w_abort_nxt;
`endif

  cdc_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.xfer_ack_async),
    .o_sync  (w_ack_s)
  );

  assign w_ready = (r_state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
`ifdef CDC_HS_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_abort <= w_abort_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_abort_nxt = r_abort;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.src_valid && w_ready) begin
          w_data_nxt  = bus.src_data;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
`ifdef CDC_HS_TIMEOUT_EN
          w_cnt_nxt   = '0;
          w_abort_nxt = 1'b0;
`endif
        end
      end
      S_REQ: begin
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_REL;
        end
`ifdef CDC_HS_TIMEOUT_EN
        // r_cnt counts completed S_REQ cycles; abort on the TIMEOUT_CYCLES-th one.
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_REL;
          w_err_nxt   = 1'b1;
          w_abort_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      S_REL: begin
        // Release is only complete once the destination has dropped ack as well.
        if (!w_ack_s) begin
          w_state_nxt = S_IDLE;
`ifdef CDC_HS_TIMEOUT_EN
          w_done_nxt  = !r_abort;
`else
          w_done_nxt  = 1'b1;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.src_ready   = w_ready;
  assign bus.xfer_req    = r_req;
  assign bus.xfer_data   = r_data;
  assign bus.xfer_done   = r_done;
`ifdef CDC_HS_TIMEOUT_EN
  assign bus.err_timeout = r_err;
`endif

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Bench for cdc_hs_sender: per-cycle vector table for a single transfer with a busy
// offer, then directed sequences for early ack, ack glitch, mid-transfer reset,
// back-to-back words and (with CDC_HS_TIMEOUT_EN) the timeout abort.
module tb_cdc_hs_sender;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned RTRIP = 2 * SYNC + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdc_hs_sender_if #(.DATASIZE(8)) bus ();

  // Destination model: either echoes req straight back as ack, or a forced level.
  logic ack_mode  = 1'b0;
  logic ack_force = 1'b0;
  assign bus.xfer_ack_async = ack_mode ? ack_force : bus.xfer_req;

  cdc_hs_sender #(
    .DATASIZE       (8),
`ifdef CDC_HS_TIMEOUT_EN
    .TIMEOUT_CYCLES (16),
`endif
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: captures the word at each req rise and counts done pulses.
  logic        mon_en   = 1'b0;
  logic        prev_req = 1'b0;
  logic [7:0]  held     = 8'h00;
  int          cyc      = 0;
  int          done_cnt = 0;
  logic [7:0]  cap_q[$];
  int          rise_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_en) begin
      if (bus.xfer_req && !prev_req) begin
        cap_q.push_back(bus.xfer_data);
        rise_q.push_back(cyc);
        held = bus.xfer_data;
      end else if (bus.xfer_req && prev_req) begin
        chk("data_stable", 32'(bus.xfer_data), 32'(held));
      end
      if (bus.xfer_done) done_cnt++;
`ifdef CDC_HS_TIMEOUT_EN
      if (bus.xfer_done && bus.err_timeout) chk("done_err_excl", 32'd1, 32'd0);
`endif
    end
    prev_req = bus.xfer_req;
  end

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_req;
    logic [7:0] exp_data;
    logic       exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (bus.xfer_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic got;
    int   d0;
    int   lat;

    // Single transfer of A5 with echoed ack; offers of FF while busy must be ignored.
    // Acceptance is at vector 0, done appears at vector 6 (RTRIP cycles counting the
    // acceptance cycle as cycle 0).
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0};

    bus.src_valid = 1'b0;
    bus.src_data  = 8'h00;

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", 32'(bus.src_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(bus.xfer_req), 32'd0);
    chk("rst_data", 32'(bus.xfer_data), 32'd0);
    chk("rst_ready", 32'(bus.src_ready), 32'd1);
    chk("rst_done", 32'(bus.xfer_done), 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bus.src_valid = vecs[i].valid;
      bus.src_data  = vecs[i].data;
      step();
      chk($sformatf("vec%0d_ready", i), 32'(bus.src_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_req", i), 32'(bus.xfer_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_data", i), 32'(bus.xfer_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_done", i), 32'(bus.xfer_done), 32'(vecs[i].exp_done));
    end
    chk("single_done_cnt", 32'(done_cnt), 32'd1);

    // Ack already high when S_REQ is entered: leave S_REQ after one cycle.
    ack_mode  = 1'b1;
    ack_force = 1'b1;
    repeat (3) step();
    chk("early_idle_ready", 32'(bus.src_ready), 32'd1);
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h3C;
    step();
    bus.src_valid = 1'b0;
    chk("early_req_hi", 32'(bus.xfer_req), 32'd1);
    chk("early_data", 32'(bus.xfer_data), 32'h3C);
    step();
    chk("early_req_lo", 32'(bus.xfer_req), 32'd0);
    ack_force = 1'b0;
    wait_done(10, seen);
    chk("early_done_seen", 32'(seen), 32'd1);

    // Sub-cycle ack glitch in S_REQ is never sampled; transfer still completes.
    ack_force = 1'b0;
    step();
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h5A;
    step();
    bus.src_valid = 1'b0;
    step();
    ack_force = 1'b1;
    #2;
    ack_force = 1'b0;
    repeat (4) step();
    chk("glitch_req_held", 32'(bus.xfer_req), 32'd1);
    chk("glitch_ready", 32'(bus.src_ready), 32'd0);
    ack_mode = 1'b0;
    wait_done(20, seen);
    chk("glitch_done_seen", 32'(seen), 32'd1);
    chk("glitch_data", 32'(bus.xfer_data), 32'h5A);

    // Reset while in S_REQ.
    step();
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h77;
    step();
    bus.src_valid = 1'b0;
    step();
    chk("mid_in_req", 32'(bus.xfer_req), 32'd1);
    d0  = done_cnt;
    rst = 1'b1;
    step();
    chk("mid_rst_req", 32'(bus.xfer_req), 32'd0);
    chk("mid_rst_data", 32'(bus.xfer_data), 32'd0);
    chk("mid_rst_done", 32'(bus.xfer_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.src_ready), 32'd1);
    repeat (8) step();
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_still_idle", 32'(bus.src_ready), 32'd1);

    // Back-to-back words with src_valid held high.
    cap_q.delete();
    rise_q.delete();
    d0 = done_cnt;
    bus.src_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      bus.src_data = 8'(w);
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (bus.src_ready) begin
          got = 1'b1;
          break;
        end
        step();
      end
      chk($sformatf("b2b_ready_w%0d", w), 32'(got), 32'd1);
      step();
    end
    bus.src_data = 8'hEE;
    wait_done(20, seen);
    bus.src_valid = 1'b0;
    chk("b2b_last_done", 32'(seen), 32'd1);
    step();
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd3);
    chk("b2b_cap_cnt", 32'(cap_q.size()), 32'd3);
    if (cap_q.size() == 3 && rise_q.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("b2b_word%0d", i), 32'(cap_q[i]), 32'(i + 1));
      chk("b2b_period0", 32'(rise_q[1] - rise_q[0]), 32'(RTRIP));
      chk("b2b_period1", 32'(rise_q[2] - rise_q[1]), 32'(RTRIP));
    end

`ifdef CDC_HS_TIMEOUT_EN
    // Ack tied low: abort after 16 cycles in S_REQ, no xfer_done.
    ack_mode  = 1'b1;
    ack_force = 1'b0;
    repeat (3) step();
    d0 = done_cnt;
    bus.src_valid = 1'b1;
    bus.src_data  = 8'hC3;
    step();
    bus.src_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.err_timeout) begin
        lat = i;
        break;
      end
    end
    chk("to_latency", 32'(lat), 32'd16);
    chk("to_req_drop", 32'(bus.xfer_req), 32'd0);
    step();
    chk("to_err_pulse", 32'(bus.err_timeout), 32'd0);
    chk("to_idle", 32'(bus.src_ready), 32'd1);
    repeat (5) step();
    chk("to_no_done", 32'(done_cnt - d0), 32'd0);
    ack_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
